// File: rtl/rhythm_pkg.sv
// rhythm_pkg: shared types and constants for the beat/period measurement blocks
package rhythm_pkg;
  localparam int PM_W = 32;
  typedef enum logic {PM_IDLE, PM_MEASURE} pm_state_t;
endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchroniser plus rising-edge detector for async beat inputs
//   clk   - sampling clock
//   reset - asynchronous active-low reset
//   d     - asynchronous input
//   s     - synchronised level
//   rise  - high for one clk when s goes 0->1
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic s,
  output logic rise
);
  logic [STAGES-1:0] sync;
  logic s_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      s_d  <= sync[STAGES-1];
    end
  assign s    = sync[STAGES-1];
  assign rise = s & ~s_d;
endmodule

// File: rtl/period_meter.sv
// period_meter: counts clk cycles between rising edges of an asynchronous input
//   clk          - system clock
//   reset        - asynchronous active-low reset
//   en           - measurement enable
//   sig_in       - asynchronous signal to measure
//   period       - cycles between the last two rising edges
//   period_valid - one-cycle strobe when period (and high_time) update
//   locked       - a period has been reported since arming
//   timeout      - sticky, no edge within MAX_COUNT cycles
//   high_time    - high cycles of the last period (only with PERIOD_METER_DUTY_EN)
module period_meter
  import rhythm_pkg::*;
#(
  parameter int             W           = PM_W,
  parameter int             SYNC_STAGES = 2,
  parameter logic [W-1:0]   MAX_COUNT   = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         sig_in,
  output logic [W-1:0] period,
  output logic         period_valid,
  output logic         locked,
`ifdef PERIOD_METER_DUTY_EN
  output logic [W-1:0] high_time,
`endif
  output logic         timeout
);
  pm_state_t state, state_nx;
  logic [W-1:0] cnt, cnt_nx, period_nx;
  logic valid_nx, locked_nx, timeout_nx, rise;
`ifdef PERIOD_METER_DUTY_EN
  logic s;
  logic [W-1:0] hcnt, hcnt_nx, high_nx;
`else
  logic s_unused;
`endif
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .reset(reset),
    .d(sig_in),
`ifdef PERIOD_METER_DUTY_EN
    .s(s),
`else
    .s(s_unused),
`endif
    .rise(rise)
  );
  // Branch order encodes priority: disable beats edge, edge beats timeout.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    period_nx  = period;
    valid_nx   = 1'b0;
    locked_nx  = locked;
    timeout_nx = timeout;
    if (state == PM_IDLE) begin
      cnt_nx = '0;
      if (en && rise) begin
        cnt_nx   = W'(1);
        state_nx = PM_MEASURE;
      end
    end else if (!en) begin
      state_nx = PM_IDLE;
      cnt_nx   = '0;
    end else if (rise) begin
      period_nx  = cnt;
      valid_nx   = 1'b1;
      locked_nx  = 1'b1;
      timeout_nx = 1'b0;
      cnt_nx     = W'(1);
    end else if (cnt == MAX_COUNT) begin
      timeout_nx = 1'b1;
      locked_nx  = 1'b0;
      state_nx   = PM_IDLE;
      cnt_nx     = '0;
    end else begin
      cnt_nx = cnt + W'(1);
    end
  end
`ifdef PERIOD_METER_DUTY_EN
  // s is already high on the rise cycle, so the high count restarts at 1.
  always_comb begin
    hcnt_nx = hcnt;
    high_nx = high_time;
    if (en && rise) begin
      hcnt_nx = W'(1);
      high_nx = (state == PM_MEASURE) ? hcnt : high_time;
    end else if (state == PM_MEASURE && s && hcnt != MAX_COUNT) begin
      hcnt_nx = hcnt + W'(1);
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      hcnt      <= '0;
      high_time <= '0;
    end else begin
      hcnt      <= hcnt_nx;
      high_time <= high_nx;
    end
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state        <= PM_IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      period       <= period_nx;
      period_valid <= valid_nx;
      locked       <= locked_nx;
      timeout      <= timeout_nx;
    end
endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed checks of period_meter (default and MAX_COUNT=16 instances)
module tb_period_meter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0, sig_in = 1'b0, en16 = 1'b0, sig16 = 1'b0;
  logic [31:0] period, period16, high, high16;
  logic valid, locked, tout, valid16, locked16, tout16;
  int checks = 0, errors = 0;
  int vc[$], vp[$], vh[$], vl[$], vt[$];
  int tc;

  always #5 clk = ~clk;

  period_meter dut (
    .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
    .period(period), .period_valid(valid), .locked(locked),
`ifdef PERIOD_METER_DUTY_EN
    .high_time(high),
`endif
    .timeout(tout)
  );

  period_meter #(.MAX_COUNT(32'd16)) dut16 (
    .clk(clk), .reset(reset), .en(en16), .sig_in(sig16),
    .period(period16), .period_valid(valid16), .locked(locked16),
`ifdef PERIOD_METER_DUTY_EN
    .high_time(high16),
`endif
    .timeout(tout16)
  );

`ifndef PERIOD_METER_DUTY_EN
  assign high = '0;
  assign high16 = '0;
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      en = 1'b0; sig_in = 1'b0; en16 = 1'b0; sig16 = 1'b0;
    end
  endtask

  // Drives a square wave (p1/h1 before cycle step, p2/h2 from step on) for n
  // cycles and logs every valid strobe plus the first cycle timeout is seen.
  task automatic run(input bit sel, input int p1, input int h1, input int p2,
                     input int h2, input int step, input int n,
                     input int en_lo, input int en_hi);
    logic s, e;
    vc.delete(); vp.delete(); vh.delete(); vl.delete(); vt.delete();
    tc = -1;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (sel ? valid16 : valid) begin
        vc.push_back(c);
        vp.push_back(int'(sel ? period16 : period));
        vh.push_back(int'(sel ? high16 : high));
        vl.push_back(int'(sel ? locked16 : locked));
        vt.push_back(int'(sel ? tout16 : tout));
      end
      if ((sel ? tout16 : tout) && tc < 0) tc = c;
      s = (c < step) ? ((c % p1) < h1) : (((c - step) % p2) < h2);
      e = !(c >= en_lo && c < en_hi);
      if (sel) begin sig16 = s; en16 = e; end
      else begin sig_in = s; en = e; end
    end
  endtask

  initial begin
    int ep[7] = '{8, 8, 8, 6, 20, 20, 20};
    int eh[7] = '{4, 4, 4, 4, 10, 10, 10};
    int ec[7] = '{11, 19, 27, 33, 53, 73, 93};
    idle(3);
    chk("rst_period", period, 0);
    chk("rst_valid", valid, 0);
    chk("rst_locked", locked, 0);
    chk("rst_timeout", tout, 0);
    chk("rst_timeout16", tout16, 0);
    @(negedge clk) reset = 1'b1;
    idle(3);

    run(0, 10, 5, 10, 5, 100, 50, 100, 100);
    chk("p10_count", vc.size(), 4);
    chk("p10_first", vc[0], 13);
    foreach (vp[i]) begin
      chk("p10_period", vp[i], 10);
      chk("p10_locked", vl[i], 1);
`ifdef PERIOD_METER_DUTY_EN
      chk("p10_high", vh[i], 5);
`endif
    end
    idle(3);
    chk("dis_hold_period", period, 10);
    chk("dis_hold_locked", locked, 1);

    run(0, 2, 1, 2, 1, 100, 20, 100, 100);
    chk("p2_count", vc.size(), 8);
    chk("p2_first", vc[0], 5);
    foreach (vp[i]) begin
      chk("p2_period", vp[i], 2);
`ifdef PERIOD_METER_DUTY_EN
      chk("p2_high", vh[i], 1);
`endif
    end
    idle(3);

    run(0, 12, 6, 12, 6, 1000, 70, 42, 45);
    chk("en_count", vc.size(), 4);
    chk("en_last_before", vc[2], 39);
    chk("en_rearm_valid", vc[3], 63);
    foreach (vp[i]) begin
      chk("en_period", vp[i], 12);
`ifdef PERIOD_METER_DUTY_EN
      chk("en_high", vh[i], 6);
`endif
    end
    idle(3);

    run(0, 8, 4, 20, 10, 30, 100, 1000, 1000);
    chk("step_count", vc.size(), 7);
    for (int i = 0; i < 7; i++) begin
      chk("step_cycle", vc[i], ec[i]);
      chk("step_period", vp[i], ep[i]);
`ifdef PERIOD_METER_DUTY_EN
      chk("step_high", vh[i], eh[i]);
`endif
    end
    idle(3);

    run(0, 10, 5, 10, 5, 100, 27, 100, 100);
    chk("pre_rst_locked", locked, 1);
    @(negedge clk);
    reset = 1'b0;
    sig_in = 1'b0;
    #1;
    chk("arst_period", period, 0);
    chk("arst_valid", valid, 0);
    chk("arst_locked", locked, 0);
    chk("arst_timeout", tout, 0);
    chk("arst_high", high, 0);
    @(negedge clk) reset = 1'b1;
    idle(2);
    run(0, 10, 5, 10, 5, 100, 30, 100, 100);
    chk("post_rst_count", vc.size(), 2);
    chk("post_rst_first", vc[0], 13);
    chk("post_rst_period", vp[0], 10);
    idle(3);

    run(1, 4, 2, 100, 0, 12, 40, 1000, 1000);
    chk("to_count", vc.size(), 2);
    chk("to_period_pre", vp[1], 4);
    chk("to_locked_pre", vl[1], 1);
    chk("to_cycle", tc, 27);
    chk("to_locked", locked16, 0);
    chk("to_period_hold", period16, 4);
    idle(3);
    chk("to_sticky", tout16, 1);

    run(1, 5, 2, 5, 2, 100, 12, 1000, 1000);
    chk("to_held_until_report", tc, 0);
    chk("to_rec_count", vc.size(), 1);
    chk("to_rec_cycle", vc[0], 8);
    chk("to_rec_period", vp[0], 5);
    chk("to_rec_cleared", vt[0], 0);
    chk("to_rec_locked", vl[0], 1);
    idle(3);

    run(1, 16, 8, 16, 8, 100, 40, 1000, 1000);
    chk("max_no_timeout", tc, -1);
    chk("max_count", vc.size(), 2);
    chk("max_period", vp[0], 16);
    chk("max_period2", vp[1], 16);
    chk("max_locked", locked16, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
